// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational Execution unit.
// One operation in flight: IDLE accepts, EXEC samples the unit, RESP holds the response.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic [4:0]       req0_shamt,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  input  logic [4:0]       req1_shamt,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       alu_shamt,
  output logic             alu_src,
  output logic [WIDTH-1:0] alu_imm,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_ovf,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LAST = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             last_grant_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [4:0]       shamt_q;

  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_ovf_q;
  logic             rsp_err_q;

  logic grant0, grant1;
  logic accept0, accept1;
  logic legal_op;
  logic arith_op;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == IDLE) && grant0;
    req1_ready = (state_q == IDLE) && grant1;
    accept0    = req0_valid && req0_ready;
    accept1    = req1_valid && req1_ready;
    legal_op   = (op_q <= OP_LAST);
    arith_op   = (op_q == OP_ADD) || (op_q == OP_SUB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      shamt_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            a_q          <= accept1 ? req1_a     : req0_a;
            b_q          <= accept1 ? req1_b     : req0_b;
            op_q         <= accept1 ? req1_op    : req0_op;
            shamt_q      <= accept1 ? req1_shamt : req0_shamt;
            id_q         <= accept1;
            last_grant_q <= accept1;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          // Illegal opcodes still walk through EXEC so latency is uniform.
          rsp_id_q     <= id_q;
          rsp_result_q <= legal_op ? alu_result : '0;
          rsp_zero_q   <= legal_op && alu_zero;
          rsp_ovf_q    <= legal_op && arith_op && alu_ovf;
          rsp_err_q    <= !legal_op;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign alu_shamt  = shamt_q;
  assign alu_src    = 1'b0;
  assign alu_imm    = '0;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width (only 32 is supported).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32 each  operands A and B.
REQ-007 req0_op / req1_op  input  4  ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SRA, 7 GT, 8 LT).
REQ-008 req0_shamt / req1_shamt  input  5  shift amount.
REQ-009 alu_a, alu_b  output  32  operands driven to the shared Execution unit.
REQ-010 alu_op  output  4; alu_shamt  output  5; alu_src  output  1, tied 0; alu_imm  output  32, tied 0.
REQ-011 alu_result  input  32; alu_zero  input  1; alu_ovf  input  1; Execution unit outputs, combinational from alu_* outputs.
REQ-012 rsp_valid  output  1; rsp_ready  input  1; response handshake.
REQ-013 rsp_id  output  1  requester served; rsp_result  output  32; rsp_zero, rsp_ovf, rsp_err  output  1 each.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 IDLE: grant = requester with valid; both valid -> requester other than last_grant (round-robin).
REQ-016 reqN_ready = (state==IDLE) && granted N, combinational; never both high; acceptance = valid && ready.
REQ-017 On acceptance: latch a, b, op, shamt, id; last_grant <= id; IDLE -> EXEC.
REQ-018 alu_a/b/op/shamt driven from latched registers in all states; hold last values in IDLE.
REQ-019 EXEC lasts exactly one cycle; at its end capture rsp_result=alu_result, rsp_zero=alu_zero, rsp_ovf=alu_ovf only when op is 0 or 1, else 0; EXEC -> RESP.
REQ-020 Opcode 9-15: rsp_err=1, rsp_result=0, rsp_zero=0, rsp_ovf=0; still takes IDLE->EXEC->RESP path; legal ops give rsp_err=0.
REQ-021 RESP: rsp_valid=1 with all rsp_* stable until rsp_ready=1; handshake cycle -> IDLE; rsp_valid low in IDLE and EXEC.
REQ-022 Latency: acceptance in cycle T -> rsp_valid high from cycle T+2; minimum 3 cycles per operation.
REQ-023 New requests accepted only in IDLE; requesters holding valid during EXEC/RESP see ready=0 and shall not be lost.
REQ-024 rsp_ready high in IDLE or EXEC has no effect.
REQ-025 A requester deasserting valid before acceptance is not served; no grant state retained for it.

Reset
REQ-026 rst_n low: state=IDLE, last_grant=1 (req0 wins first tie), latched operands/op/shamt=0, all rsp_* =0, ready outputs per REQ-016.
REQ-027 Reset in EXEC or RESP discards the in-flight operation; no response emitted after release.
REQ-028 First grant possible in the first rising edge with rst_n high.

Verification
REQ-029 req0 a=-15, b=-22, op=0, rsp_ready=1 -> rsp_result=-37, rsp_ovf=0, rsp_zero=0, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-030 Both valid after reset, op=1, req0 a=5 b=5, req1 a=3 b=7 -> req0 served first (result 0, zero=1), then req1 (result -4); next tie goes to req0.
REQ-031 req1 a=0x7FFFFFFF, b=1, op=0 -> rsp_result=0x80000000, rsp_ovf=1; same operands op=3 -> rsp_ovf=0.
REQ-032 rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_result stable, req0/req1_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-033 op=12 on req0 -> rsp_err=1, rsp_result=0; following op=4, a=1, shamt=3 -> rsp_result=8, rsp_err=0.
REQ-034 rst_n pulsed low during EXEC -> all rsp_* = 0 immediately, no response after release, next accepted request served normally.
